// File: rtl/fifo_mem_scheduler_if.sv
// rtl/fifo_mem_scheduler_if.sv - burst command handshake between scheduler and RAM burst engine
interface fifo_mem_scheduler_if #(
   parameter int NUM_CH     = 8,
   parameter int ADDR_WIDTH = 23
);
   localparam int CH_W = $clog2(NUM_CH);

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [CH_W-1:0]       cmd_ch;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic                  cmd_done;

   modport master (
      output cmd_valid, cmd_write, cmd_ch, cmd_addr,
      input  cmd_ready, cmd_done
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_ch, cmd_addr,
      output cmd_ready, cmd_done
   );
endinterface

// File: rtl/fifo_mem_scheduler.sv
// rtl/fifo_mem_scheduler.sv - round-robin cell-RAM burst scheduler for capture/playback tracking FIFOs
// Optional WAIT-state watchdog and wdog_err port: define SCHED_WATCHDOG_EN.
module fifo_mem_scheduler #(
   parameter int NUM_CH      = 8,
   parameter int COUNT_WIDTH = 11,
   parameter int ADDR_WIDTH  = 23,
   parameter int BURST_LEN   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_CH-1:0]             ch_enable,
   input  logic [NUM_CH*COUNT_WIDTH-1:0] write_fifo_byte_counts,
   input  logic [NUM_CH*COUNT_WIDTH-1:0] read_fifo_space_counts,
   fifo_mem_scheduler_if.master          cmd,
   output logic                          busy,
   output logic [NUM_CH-1:0]             region_full,
   output logic [NUM_CH-1:0]             region_empty
`ifdef SCHED_WATCHDOG_EN
   ,
   output logic                          wdog_err
`endif
);
   localparam int CH_W   = $clog2(NUM_CH);
   localparam int NSLOT  = 2 * NUM_CH;
   localparam int SLOT_W = $clog2(NSLOT);
   localparam int RW     = ADDR_WIDTH - CH_W;
   localparam int PW     = RW + 1;

   localparam logic [PW-1:0]          BL_P     = PW'(BURST_LEN);
   localparam logic [PW-1:0]          FULL_LVL = PW'((2 ** RW) - BURST_LEN);
   localparam logic [COUNT_WIDTH-1:0] MIN_CNT  = COUNT_WIDTH'(2 * BURST_LEN);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t                state_q;
   logic [PW-1:0]         wp_q [NUM_CH];
   logic [PW-1:0]         rp_q [NUM_CH];
   logic [NUM_CH-1:0]     en_q;
   logic [NUM_CH-1:0]     clr_pend_q;
   logic [SLOT_W-1:0]     last_grant_q;
   logic [SLOT_W-1:0]     gnt_slot_q;
   logic                  cmd_valid_q;
   logic                  cmd_write_q;
   logic [CH_W-1:0]       cmd_ch_q;
   logic [ADDR_WIDTH-1:0] cmd_addr_q;
   logic                  busy_q;
   logic [NUM_CH-1:0]     region_full_q;
   logic [NUM_CH-1:0]     region_empty_q;

   logic [NUM_CH-1:0]     rise;
   logic [PW-1:0]         wp_eff [NUM_CH];
   logic [PW-1:0]         rp_eff [NUM_CH];
   logic [PW-1:0]         lvl_eff;
   logic [PW-1:0]         lvl_q [NUM_CH];
   logic [NSLOT-1:0]      req;
   logic [NUM_CH-1:0]     region_full_d;
   logic [NUM_CH-1:0]     region_empty_d;
   logic                  found_d;
   logic [SLOT_W-1:0]     slot_d;
   logic [SLOT_W-1:0]     idx;
   logic [CH_W-1:0]       gnt_ch_d;
   logic                  gnt_write_d;
   logic [PW-1:0]         gnt_ptr_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic                  wdog_to;

   // A channel seeing its enable rise this cycle is evaluated as if already cleared.
   always_comb begin
      rise    = ch_enable & ~en_q;
      req     = '0;
      lvl_eff = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         wp_eff[c]  = rise[c] ? '0 : wp_q[c];
         rp_eff[c]  = rise[c] ? '0 : rp_q[c];
         lvl_eff    = wp_eff[c] - rp_eff[c];
         req[2*c]   = ch_enable[c]
                      && (write_fifo_byte_counts[c*COUNT_WIDTH +: COUNT_WIDTH] >= MIN_CNT)
                      && (lvl_eff <= FULL_LVL);
         req[2*c+1] = ch_enable[c]
                      && (read_fifo_space_counts[c*COUNT_WIDTH +: COUNT_WIDTH] >= MIN_CNT)
                      && (lvl_eff >= BL_P);
      end
   end

   always_comb begin
      region_full_d  = '0;
      region_empty_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         lvl_q[c]          = wp_q[c] - rp_q[c];
         region_full_d[c]  = lvl_q[c] > FULL_LVL;
         region_empty_d[c] = lvl_q[c] < BL_P;
      end
   end

   // Search starts one past the last accepted slot; the last slot itself is tried last.
   always_comb begin
      found_d = 1'b0;
      slot_d  = '0;
      idx     = '0;
      for (int i = 1; i <= NSLOT; i++) begin
         idx = last_grant_q + SLOT_W'(i);
         if (!found_d && req[idx]) begin
            found_d = 1'b1;
            slot_d  = idx;
         end
      end
      gnt_ch_d    = slot_d[SLOT_W-1:1];
      gnt_write_d = ~slot_d[0];
      gnt_ptr_d   = gnt_write_d ? wp_eff[gnt_ch_d] : rp_eff[gnt_ch_d];
      addr_d      = {gnt_ch_d, gnt_ptr_d[RW-1:0]};
   end

`ifdef SCHED_WATCHDOG_EN
   logic [9:0] wdog_cnt_q;
   logic       wdog_err_q;

   assign wdog_to  = (state_q == S_WAIT) && !cmd.cmd_done && (wdog_cnt_q == 10'h3FF);
   assign wdog_err = wdog_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdog_cnt_q <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         if (state_q == S_ISSUE && cmd.cmd_ready) begin
            wdog_cnt_q <= '0;
         end else if (state_q == S_WAIT) begin
            wdog_cnt_q <= wdog_cnt_q + 10'd1;
         end
         if (wdog_to) begin
            wdog_err_q <= 1'b1;
         end
      end
   end
`else
   assign wdog_to = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         en_q           <= '0;
         clr_pend_q     <= '0;
         last_grant_q   <= SLOT_W'(NSLOT - 1);
         gnt_slot_q     <= '0;
         cmd_valid_q    <= 1'b0;
         cmd_write_q    <= 1'b0;
         cmd_ch_q       <= '0;
         cmd_addr_q     <= '0;
         busy_q         <= 1'b0;
         region_full_q  <= '0;
         region_empty_q <= '1;
         for (int c = 0; c < NUM_CH; c++) begin
            wp_q[c] <= '0;
            rp_q[c] <= '0;
         end
      end else begin
         en_q           <= ch_enable;
         region_full_q  <= region_full_d;
         region_empty_q <= region_empty_d;

         // The outstanding channel keeps its pointers until its burst retires.
         for (int c = 0; c < NUM_CH; c++) begin
            if (rise[c]) begin
               if (state_q != S_IDLE && cmd_ch_q == CH_W'(c)) begin
                  clr_pend_q[c] <= 1'b1;
               end else begin
                  wp_q[c] <= '0;
                  rp_q[c] <= '0;
               end
            end
         end

         case (state_q)
            S_IDLE: begin
               if (found_d) begin
                  state_q     <= S_ISSUE;
                  gnt_slot_q  <= slot_d;
                  cmd_write_q <= gnt_write_d;
                  cmd_ch_q    <= gnt_ch_d;
                  cmd_addr_q  <= addr_d;
                  cmd_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (cmd.cmd_ready) begin
                  state_q      <= S_WAIT;
                  cmd_valid_q  <= 1'b0;
                  last_grant_q <= gnt_slot_q;
               end
            end
            S_WAIT: begin
               if (cmd.cmd_done || wdog_to) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  if (cmd.cmd_done) begin
                     if (cmd_write_q) begin
                        wp_q[cmd_ch_q] <= wp_q[cmd_ch_q] + BL_P;
                     end else begin
                        rp_q[cmd_ch_q] <= rp_q[cmd_ch_q] + BL_P;
                     end
                  end
                  if (clr_pend_q[cmd_ch_q] || rise[cmd_ch_q]) begin
                     wp_q[cmd_ch_q]       <= '0;
                     rp_q[cmd_ch_q]       <= '0;
                     clr_pend_q[cmd_ch_q] <= 1'b0;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd.cmd_valid = cmd_valid_q;
   assign cmd.cmd_write = cmd_write_q;
   assign cmd.cmd_ch    = cmd_ch_q;
   assign cmd.cmd_addr  = cmd_addr_q;
   assign busy          = busy_q;
   assign region_full   = region_full_q;
   assign region_empty  = region_empty_q;
endmodule

// File: tb/tb_fifo_mem_scheduler.sv
// tb/tb_fifo_mem_scheduler.sv - directed self-checking bench for fifo_mem_scheduler
module tb_fifo_mem_scheduler;
   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  ch_enable;
   logic [87:0] wcnt;
   logic [87:0] rspace;
   logic        cmd_ready;
   logic        busy_m, busy_s;
   logic [7:0]  full_m, empty_m, full_s, empty_s;
   logic        sel;
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   // Main instance uses default geometry; the small one (256-word regions) makes region wrap reachable.
   fifo_mem_scheduler_if #(.NUM_CH(8), .ADDR_WIDTH(23)) cm ();
   fifo_mem_scheduler_if #(.NUM_CH(8), .ADDR_WIDTH(11)) cs ();

   assign cm.cmd_ready = cmd_ready;
   assign cs.cmd_ready = cmd_ready;

   fifo_mem_scheduler #(.NUM_CH(8), .COUNT_WIDTH(11), .ADDR_WIDTH(23), .BURST_LEN(16)) dut_m (
      .clk(clk), .reset(reset), .ch_enable(ch_enable),
      .write_fifo_byte_counts(wcnt), .read_fifo_space_counts(rspace),
      .cmd(cm), .busy(busy_m), .region_full(full_m), .region_empty(empty_m)
   );

   fifo_mem_scheduler #(.NUM_CH(8), .COUNT_WIDTH(11), .ADDR_WIDTH(11), .BURST_LEN(16)) dut_s (
      .clk(clk), .reset(reset), .ch_enable(ch_enable),
      .write_fifo_byte_counts(wcnt), .read_fifo_space_counts(rspace),
      .cmd(cs), .busy(busy_s), .region_full(full_s), .region_empty(empty_s)
   );

   task automatic wait_cmd(output bit got, output logic w, output logic [2:0] ch, output logic [22:0] addr);
      got = 0; w = 0; ch = 0; addr = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (sel ? cs.cmd_valid : cm.cmd_valid) begin
            got  = 1;
            w    = sel ? cs.cmd_write : cm.cmd_write;
            ch   = sel ? cs.cmd_ch : cm.cmd_ch;
            addr = sel ? {12'd0, cs.cmd_addr} : cm.cmd_addr;
         end
      end
   endtask

   task automatic pulse_done();
      @(negedge clk);
      if (sel) cs.cmd_done = 1'b1; else cm.cmd_done = 1'b1;
      @(negedge clk);
      cm.cmd_done = 1'b0;
      cs.cmd_done = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; ch_enable = '0; wcnt = '0; rspace = '0; cmd_ready = 1'b1;
      cm.cmd_done = 1'b0; cs.cmd_done = 1'b0; sel = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (cm.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", cm.cmd_valid); end
      n_cmp++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_m); end
      n_cmp++; if (cm.cmd_write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b want 0", cm.cmd_write); end
      n_cmp++; if (cm.cmd_ch !== 3'd0) begin n_fail++; $display("FAIL rst_ch: got %0d want 0", cm.cmd_ch); end
      n_cmp++; if (cm.cmd_addr !== 23'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", cm.cmd_addr); end
      n_cmp++; if (full_m !== 8'h00) begin n_fail++; $display("FAIL rst_full: got %h want 00", full_m); end
      n_cmp++; if (empty_m !== 8'hFF) begin n_fail++; $display("FAIL rst_empty: got %h want ff", empty_m); end
   endtask

   task automatic test_first_write();
      sel = 1'b0;
      ch_enable = 8'h01;
      wcnt[10:0] = 11'd32;
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (cm.cmd_valid !== 1'b1 || cm.cmd_write !== 1'b1 || cm.cmd_ch !== 3'd0 || cm.cmd_addr !== 23'd0) begin
         n_fail++;
         $display("FAIL first_cmd: got v=%b w=%b ch=%0d addr=%h want v=1 w=1 ch=0 addr=000000",
                  cm.cmd_valid, cm.cmd_write, cm.cmd_ch, cm.cmd_addr);
      end
      wcnt = '0;
      @(negedge clk);
      n_cmp++;
      if (cm.cmd_valid !== 1'b0 || busy_m !== 1'b1) begin
         n_fail++; $display("FAIL first_wait: got v=%b busy=%b want v=0 busy=1", cm.cmd_valid, busy_m);
      end
      cm.cmd_done = 1'b1;
      @(negedge clk);
      cm.cmd_done = 1'b0;
      n_cmp++; if (empty_m[0] !== 1'b1) begin n_fail++; $display("FAIL empty_lag: got %b want 1", empty_m[0]); end
      @(negedge clk);
      n_cmp++; if (empty_m[0] !== 1'b0) begin n_fail++; $display("FAIL empty_after: got %b want 0", empty_m[0]); end
      n_cmp++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy_m); end
   endtask

   task automatic test_alternate();
      bit got; logic w; logic [2:0] ch; logic [22:0] a;
      logic        ew [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [22:0] ea [4] = '{23'h000000, 23'h000010, 23'h000010, 23'h000020};
      sel = 1'b0;
      wcnt[10:0] = 11'd32; rspace[10:0] = 11'd32;
      for (int i = 0; i < 4; i++) begin
         wait_cmd(got, w, ch, a);
         if (i == 3) begin wcnt = '0; rspace = '0; end
         n_cmp++;
         if (!got || w !== ew[i] || ch !== 3'd0 || a !== ea[i]) begin
            n_fail++; $display("FAIL alt_burst%0d: got seen=%0d w=%b ch=%0d addr=%h want w=%b ch=0 addr=%h",
                               i, got, w, ch, a, ew[i], ea[i]);
         end
         pulse_done();
      end
      pulse_done();
      wcnt[10:0] = 11'd32;
      wait_cmd(got, w, ch, a);
      wcnt = '0;
      n_cmp++;
      if (!got || w !== 1'b1 || a !== 23'h000030) begin
         n_fail++; $display("FAIL idle_done_ignored: got seen=%0d w=%b addr=%h want w=1 addr=000030", got, w, a);
      end
      pulse_done();
      ch_enable = 8'h00;
      @(negedge clk);
      ch_enable = 8'h01;
      wcnt[10:0] = 11'd32;
      wait_cmd(got, w, ch, a);
      wcnt = '0;
      n_cmp++;
      if (!got || w !== 1'b1 || a !== 23'h000000) begin
         n_fail++; $display("FAIL enable_clear: got seen=%0d w=%b addr=%h want w=1 addr=000000", got, w, a);
      end
      pulse_done();
   endtask

   task automatic test_round_robin();
      bit got; logic w; logic [2:0] ch; logic [22:0] a;
      logic [2:0] ec; logic [22:0] ea;
      sel = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      ch_enable = 8'hFF;
      for (int c = 0; c < 8; c++) wcnt[c*11 +: 11] = 11'd2047;
      rspace = '0;
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         ec = 3'(i % 8);
         ea = {ec, 20'((i / 8) * 16)};
         wait_cmd(got, w, ch, a);
         if (i == 11) wcnt = '0;
         n_cmp++;
         if (!got || w !== 1'b1 || ch !== ec || a !== ea) begin
            n_fail++; $display("FAIL rr_burst%0d: got seen=%0d w=%b ch=%0d addr=%h want w=1 ch=%0d addr=%h",
                               i, got, w, ch, a, ec, ea);
         end
         pulse_done();
      end
   endtask

   task automatic test_region_full();
      bit got; logic w; logic [2:0] ch; logic [22:0] a;
      logic [22:0] ea;
      bit seen;
      sel = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      ch_enable = 8'h20;
      wcnt = '0; rspace = '0;
      wcnt[5*11 +: 11] = 11'd2047;
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ea = 23'h500 + 23'(i * 16);
         wait_cmd(got, w, ch, a);
         n_cmp++;
         if (!got || w !== 1'b1 || ch !== 3'd5 || a !== ea) begin
            n_fail++; $display("FAIL fill_burst%0d: got seen=%0d w=%b ch=%0d addr=%h want w=1 ch=5 addr=%h",
                               i, got, w, ch, a, ea);
         end
         if (i == 15) begin
            n_cmp++; if (full_s[5] !== 1'b0) begin n_fail++; $display("FAIL full_at_240: got %b want 0", full_s[5]); end
         end
         pulse_done();
      end
      @(negedge clk);
      n_cmp++;
      if (full_s[5] !== 1'b1 || empty_s[5] !== 1'b0) begin
         n_fail++; $display("FAIL full_at_256: got full=%b empty=%b want full=1 empty=0", full_s[5], empty_s[5]);
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (cs.cmd_valid !== 1'b0 || busy_s !== 1'b0) seen = 1;
      end
      n_cmp++; if (seen) begin n_fail++; $display("FAIL full_no_grant: got activity=1 want 0"); end
      rspace[5*11 +: 11] = 11'd32;
      wait_cmd(got, w, ch, a);
      rspace = '0;
      n_cmp++;
      if (!got || w !== 1'b0 || ch !== 3'd5 || a !== 23'h500) begin
         n_fail++; $display("FAIL drain_read: got seen=%0d w=%b ch=%0d addr=%h want w=0 ch=5 addr=500", got, w, ch, a);
      end
      pulse_done();
      wait_cmd(got, w, ch, a);
      wcnt = '0;
      n_cmp++;
      if (!got || w !== 1'b1 || a !== 23'h500) begin
         n_fail++; $display("FAIL wrap_write: got seen=%0d w=%b addr=%h want w=1 addr=500", got, w, a);
      end
      n_cmp++; if (full_s[5] !== 1'b0) begin n_fail++; $display("FAIL full_cleared: got %b want 0", full_s[5]); end
      pulse_done();
   endtask

   task automatic test_stall_reset();
      bit got; logic w; logic [2:0] ch; logic [22:0] a;
      sel = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      ch_enable = 8'h04;
      wcnt = '0; rspace = '0;
      wcnt[2*11 +: 11] = 11'd32;
      cmd_ready = 1'b0;
      reset = 1'b0;
      wait_cmd(got, w, ch, a);
      n_cmp++;
      if (!got || w !== 1'b1 || ch !== 3'd2 || a !== 23'h200000) begin
         n_fail++; $display("FAIL stall_cmd: got seen=%0d w=%b ch=%0d addr=%h want w=1 ch=2 addr=200000", got, w, ch, a);
      end
      wcnt = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if (cm.cmd_valid !== 1'b1 || cm.cmd_write !== 1'b1 || cm.cmd_ch !== 3'd2 || cm.cmd_addr !== 23'h200000) begin
            n_fail++; $display("FAIL stall_hold%0d: got v=%b w=%b ch=%0d addr=%h want v=1 w=1 ch=2 addr=200000",
                               i, cm.cmd_valid, cm.cmd_write, cm.cmd_ch, cm.cmd_addr);
         end
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (cm.cmd_valid !== 1'b0 || busy_m !== 1'b1) begin
         n_fail++; $display("FAIL stall_accept: got v=%b busy=%b want v=0 busy=1", cm.cmd_valid, busy_m);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (cm.cmd_valid !== 1'b0 || busy_m !== 1'b0 || cm.cmd_write !== 1'b0 || cm.cmd_ch !== 3'd0
          || cm.cmd_addr !== 23'd0 || full_m !== 8'h00 || empty_m !== 8'hFF) begin
         n_fail++; $display("FAIL midwait_reset: got v=%b busy=%b w=%b ch=%0d addr=%h full=%h empty=%h want all reset values",
                            cm.cmd_valid, busy_m, cm.cmd_write, cm.cmd_ch, cm.cmd_addr, full_m, empty_m);
      end
      @(negedge clk);
      reset = 1'b0;
      ch_enable = '0;
   endtask

   initial begin
      test_reset();
      test_first_write();
      test_alternate();
      test_round_robin();
      test_region_full();
      test_stall_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no completion want completion within 1ms");
      $fatal(1);
   end
endmodule
